// File: rtl/cpu_pkg.sv
// Shared front-end definitions: datapath widths, fetch FSM encoding and small
// address helpers used by the fetch stage.
package cpu_pkg;

    localparam int unsigned ADDR_WIDTH        = 32;
    localparam int unsigned INSTRUCTION_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // Instructions are word aligned; any low-bit set marks a bad fetch target.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, a one-outstanding-request memory FSM and a
// one-entry output buffer presenting {pc, instruction} packets to decode.
module fetch_stage #(
    parameter int unsigned           ADDR_WIDTH        = cpu_pkg::ADDR_WIDTH,
    parameter int unsigned           INSTRUCTION_WIDTH = cpu_pkg::INSTRUCTION_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR      = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         next_stall,
    output logic                         done_next,
    input  logic                         control_flow_affected,
    input  logic [ADDR_WIDTH-1:0]        jump_target,
    input  logic                         jump_target_valid,
    output logic [ADDR_WIDTH-1:0]        imem_addr,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_resp_data,
    input  logic                         imem_resp_valid,
    input  logic                         imem_resp_error,
    output logic [ADDR_WIDTH-1:0]        program_count,
    output logic                         program_count_valid,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_data,
    output logic                         instruction_data_valid
);

    import cpu_pkg::fetch_state_t;
    import cpu_pkg::IDLE;
    import cpu_pkg::WAIT;
    import cpu_pkg::DISCARD;
    import cpu_pkg::is_misaligned;

    fetch_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0]        pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]        fetch_addr_q;
    logic                         has_output_q;
    logic [ADDR_WIDTH-1:0]        pkt_pc_q;
    logic                         pkt_pc_valid_q;
    logic [INSTRUCTION_WIDTH-1:0] pkt_instr_q;
    logic                         pkt_instr_valid_q;

    logic redirect;
    logic offer;
    logic transfer;
    logic slot_free;
    logic fetch_ok;
    logic misaligned;
    logic req_fire;
    logic resp_load;
    logic placeholder_load;

    assign redirect   = control_flow_affected && jump_target_valid;
    // Never offer while decode is steering control flow: the packet may be wrong-path.
    assign offer      = !rst && has_output_q && !control_flow_affected;
    assign transfer   = offer && !next_stall;
    assign slot_free  = !has_output_q || transfer;
    assign fetch_ok   = !rst && (state_q == IDLE) && !control_flow_affected && slot_free;
    assign misaligned = is_misaligned(pc_q[1:0]);

    assign req_fire         = imem_req_valid && imem_req_ready;
    assign resp_load        = (state_q == WAIT) && imem_resp_valid && !redirect;
    // A misaligned pc produces an exception packet locally instead of a memory access.
    assign placeholder_load = fetch_ok && misaligned;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_fire) state_d = WAIT;
            end
            WAIT: begin
                // A response coinciding with a redirect is simply dropped.
                if (imem_resp_valid)  state_d = IDLE;
                else if (redirect)    state_d = DISCARD;
            end
            DISCARD: begin
                if (imem_resp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = fetch_ok && !misaligned;
        imem_addr      = pc_q;
        done_next      = offer;
    end

    // ------------------------------------------------------------ PC
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = jump_target;
        end else if (req_fire || placeholder_load) begin
            pc_d = pc_q + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            fetch_addr_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (req_fire) fetch_addr_q <= pc_q;
        end
    end

    // ----------------------------------------------------- output buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            has_output_q      <= 1'b0;
            pkt_pc_q          <= '0;
            pkt_pc_valid_q    <= 1'b0;
            pkt_instr_q       <= '0;
            pkt_instr_valid_q <= 1'b0;
        end else if (redirect) begin
            has_output_q      <= 1'b0;
            pkt_pc_valid_q    <= 1'b0;
            pkt_instr_valid_q <= 1'b0;
        end else if (resp_load) begin
            has_output_q      <= 1'b1;
            pkt_pc_q          <= fetch_addr_q;
            pkt_pc_valid_q    <= 1'b1;
            pkt_instr_q       <= imem_resp_data;
            pkt_instr_valid_q <= !imem_resp_error;
        end else if (placeholder_load) begin
            has_output_q      <= 1'b1;
            pkt_pc_q          <= pc_q;
            pkt_pc_valid_q    <= 1'b1;
            pkt_instr_q       <= '0;
            pkt_instr_valid_q <= 1'b0;
        end else if (transfer) begin
            has_output_q      <= 1'b0;
            pkt_pc_valid_q    <= 1'b0;
            pkt_instr_valid_q <= 1'b0;
        end
    end

    assign program_count          = pkt_pc_q;
    assign program_count_valid    = pkt_pc_valid_q;
    assign instruction_data       = pkt_instr_q;
    assign instruction_data_valid = pkt_instr_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table for steady-state
// fetch and stall, plus hand-written redirect, hold, error and reset sequences.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        next_stall = 1'b0;
    logic        done_next;
    logic        cfa = 1'b0;
    logic [31:0] jump_target = '0;
    logic        jtv = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_resp_data = '0;
    logic        imem_resp_valid = 1'b0;
    logic        imem_resp_error = 1'b0;
    logic [31:0] program_count;
    logic        program_count_valid;
    logic [31:0] instruction_data;
    logic        instruction_data_valid;

    fetch_stage #(
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .next_stall             (next_stall),
        .done_next              (done_next),
        .control_flow_affected  (cfa),
        .jump_target            (jump_target),
        .jump_target_valid      (jtv),
        .imem_addr              (imem_addr),
        .imem_req_valid         (imem_req_valid),
        .imem_req_ready         (imem_req_ready),
        .imem_resp_data         (imem_resp_data),
        .imem_resp_valid        (imem_resp_valid),
        .imem_resp_error        (imem_resp_error),
        .program_count          (program_count),
        .program_count_valid    (program_count_valid),
        .instruction_data       (instruction_data),
        .instruction_data_valid (instruction_data_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
    } pend_t;

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_done;
        logic [31:0] exp_pc;
    } vec_t;

    pend_t       pend_q[$];
    vec_t        vecs[14];
    int unsigned cyc = 0;
    int unsigned lat = 1;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        settled = 1'b0;
    logic        fired;
    logic [31:0] fired_addr;
    int          fires_102 = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5EED_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Let combinational outputs settle, then log the handshake the DUT will see at the edge.
    task automatic settle();
        #1;
        settled    = 1'b1;
        fired      = imem_req_valid && imem_req_ready;
        fired_addr = imem_addr;
        if (fired) begin
            pend_q.push_back('{due: cyc + lat, addr: imem_addr});
            if (imem_addr == 32'h0000_0102) fires_102++;
        end
    endtask

    task automatic clock_edge();
        pend_t p;
        if (!settled) settle();
        settled = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        imem_resp_valid = 1'b0;
        imem_resp_error = 1'b0;
        imem_resp_data  = '0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_data(p.addr);
            imem_resp_error = (p.addr == err_addr);
        end
    endtask

    task automatic do_reset(input bit flush);
        rst = 1'b1; cfa = 1'b0; jtv = 1'b0; next_stall = 1'b0;
        settle();
        check_bit("rst req_valid", imem_req_valid, 1'b0);
        check_bit("rst done_next", done_next, 1'b0);
        clock_edge();
        settle();
        check_bit("rst req_valid2", imem_req_valid, 1'b0);
        check_bit("rst pc_valid", program_count_valid, 1'b0);
        check_bit("rst instr_valid", instruction_data_valid, 1'b0);
        check("rst program_count", program_count, 32'h0);
        check("rst instruction_data", instruction_data, 32'h0);
        clock_edge();
        rst = 1'b0;
        if (flush) begin
            pend_q.delete();
            imem_resp_valid = 1'b0;
        end
    endtask

    task automatic redirect_cycle(input logic [31:0] target);
        cfa = 1'b1; jtv = 1'b1; jump_target = target;
        settle();
        check_bit("redirect done_next", done_next, 1'b0);
        check_bit("redirect req_valid", imem_req_valid, 1'b0);
        clock_edge();
        cfa = 1'b0; jtv = 1'b0;
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp_addr);
        for (int i = 0; i < 50; i++) begin
            settle();
            if (fired) begin
                check(name, fired_addr, exp_addr);
                clock_edge();
                return;
            end
            clock_edge();
        end
        n_checks++; n_fail++;
        $display("FAIL %s: no request within 50 cycles, expected addr %h", name, exp_addr);
    endtask

    task automatic wait_xfer(input string name, input logic [31:0] exp_pc, input logic exp_idv);
        for (int i = 0; i < 50; i++) begin
            settle();
            if (done_next && !next_stall) begin
                check({name, " pc"}, program_count, exp_pc);
                check_bit({name, " pc_valid"}, program_count_valid, 1'b1);
                check_bit({name, " instr_valid"}, instruction_data_valid, exp_idv);
                if (exp_idv) check({name, " data"}, instruction_data, mem_data(exp_pc));
                clock_edge();
                return;
            end
            clock_edge();
        end
        n_checks++; n_fail++;
        $display("FAIL %s: no transfer within 50 cycles, expected pc %h", name, exp_pc);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 50; i++) begin
            settle();
            if (done_next) begin
                clock_edge();
                return;
            end
            clock_edge();
        end
        n_checks++; n_fail++;
        $display("FAIL %s: done_next never rose within 50 cycles", name);
    endtask

    initial begin
        // 1-cycle memory, ready=1: one fetch per two cycles; pc=8 held under a 5-cycle stall.
        vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h4};
        vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h8};
        vecs[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h8};
        vecs[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h8};
        vecs[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h8};
        vecs[10] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h8};
        vecs[11] = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h8};
        vecs[12] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'hC};

        lat = 1;
        do_reset(1'b1);
        for (int k = 0; k < 14; k++) begin
            next_stall = vecs[k].stall;
            settle();
            check_bit($sformatf("A%0d req_valid", k), imem_req_valid, vecs[k].exp_req);
            if (vecs[k].exp_req) check($sformatf("A%0d imem_addr", k), imem_addr, vecs[k].exp_addr);
            check_bit($sformatf("A%0d done_next", k), done_next, vecs[k].exp_done);
            if (vecs[k].exp_done) begin
                check($sformatf("A%0d pc", k), program_count, vecs[k].exp_pc);
                check_bit($sformatf("A%0d pc_valid", k), program_count_valid, 1'b1);
                check_bit($sformatf("A%0d instr_valid", k), instruction_data_valid, 1'b1);
                check($sformatf("A%0d data", k), instruction_data, mem_data(vecs[k].exp_pc));
            end
            clock_edge();
        end
        next_stall = 1'b0;

        // Redirect while the 0xC request is outstanding (3-cycle memory): 0xC never reaches decode.
        lat = 3;
        do_reset(1'b1);
        wait_req("B req 0", 32'h0);
        wait_req("B req 4", 32'h4);
        wait_req("B req 8", 32'h8);
        wait_req("B req C", 32'hC);
        redirect_cycle(32'h100);
        wait_req("B req 100", 32'h100);
        wait_xfer("B pkt 100", 32'h100, 1'b1);

        // Redirect landing on the same cycle as the response.
        lat = 1;
        do_reset(1'b1);
        wait_req("B2 req 0", 32'h0);
        redirect_cycle(32'h200);
        wait_req("B2 req 200", 32'h200);
        wait_xfer("B2 pkt 200", 32'h200, 1'b1);

        // Hold for three cycles over a buffered packet, then a repeated redirect to 0x40.
        do_reset(1'b1);
        next_stall = 1'b1;
        wait_req("C req 0", 32'h0);
        wait_done("C first packet");
        next_stall = 1'b0;
        for (int h = 0; h < 3; h++) begin
            cfa = 1'b1; jtv = 1'b0;
            settle();
            check_bit($sformatf("C hold%0d done_next", h), done_next, 1'b0);
            check_bit($sformatf("C hold%0d req_valid", h), imem_req_valid, 1'b0);
            clock_edge();
        end
        redirect_cycle(32'h40);
        redirect_cycle(32'h40);
        wait_req("C req 40", 32'h40);
        wait_xfer("C pkt 40", 32'h40, 1'b1);

        // Error response on 0x20, then a misaligned redirect producing a local exception packet.
        do_reset(1'b1);
        err_addr = 32'h20;
        redirect_cycle(32'h20);
        wait_xfer("D pkt 20 err", 32'h20, 1'b0);
        fires_102 = 0;
        redirect_cycle(32'h102);
        wait_xfer("D pkt 102 misaligned", 32'h102, 1'b0);
        check("D no request for 0x102", 32'(fires_102), 32'h0);
        err_addr = 32'hFFFF_FFFF;

        // Reset mid-WAIT; the stale 0x80 response lands after release and must be ignored.
        lat = 4;
        do_reset(1'b1);
        redirect_cycle(32'h80);
        wait_req("E req 80", 32'h80);
        clock_edge();
        do_reset(1'b0);
        wait_req("E first req after reset", 32'h0);
        wait_xfer("E pkt 0", 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
